// File: rtl/knn_seq_ctrl.sv
// Sequential k-NN classifier controller: streams stored points through one distance unit,
// keeps a sorted K-best list and majority-votes the class of the query.
module knn_seq_ctrl #(
   parameter int unsigned NPoints = 17,
   parameter int unsigned K       = 3,
   parameter int unsigned Classes = 2,
   parameter int unsigned CoordW  = 16,
   localparam int unsigned AW = (NPoints > 1) ? $clog2(NPoints) : 1,
   localparam int unsigned CW = (Classes > 1) ? $clog2(Classes) : 1,
   localparam int unsigned DW = 2*CoordW + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [CoordW-1:0] in_x_i,
   input  logic [CoordW-1:0] in_y_i,
   output logic              mem_re_o,
   output logic [AW-1:0]     mem_addr_o,
   input  logic [CoordW-1:0] mem_x_i,
   input  logic [CoordW-1:0] mem_y_i,
   input  logic [CW-1:0]     mem_class_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [CW-1:0]     out_class_o,
   output logic [DW-1:0]     out_min_dist_o,
   output logic              busy_o
);

   localparam int unsigned SW = 2*CoordW;
   localparam int unsigned NW = $clog2(K + 1);

   typedef enum logic [2:0] {IDLE, RUN, DRAIN, VOTE, DONE} state_e;

   state_e            state_q, state_d;
   logic              accept;
   logic [AW-1:0]     cnt_q, cnt_d;
   logic [CoordW-1:0] qx_q, qy_q;
   logic              rvalid_q;
   logic [DW-1:0]     dist_q [K];
   logic [DW-1:0]     dist_d [K];
   logic [CW-1:0]     cls_q  [K];
   logic [CW-1:0]     cls_d  [K];
   logic              in_ready_q, in_ready_d;
   logic              busy_q, busy_d;
   logic              mem_re_q, mem_re_d;
   logic              out_valid_q, out_valid_d;
   logic [CW-1:0]     out_class_q;
   logic [DW-1:0]     out_min_q;
   logic [CoordW-1:0] dx, dy;
   logic [SW-1:0]     sqx, sqy;
   logic [DW-1:0]     dist_new;
   logic [CW-1:0]     vote_cls;
   logic [NW-1:0]     best_cnt, cls_cnt;

   assign accept = (state_q == IDLE) & in_valid_i;

   // Squared Euclidean distance at full precision
   assign dx       = (mem_x_i >= qx_q) ? mem_x_i - qx_q : qx_q - mem_x_i;
   assign dy       = (mem_y_i >= qy_q) ? mem_y_i - qy_q : qy_q - mem_y_i;
   assign sqx      = SW'(dx) * SW'(dx);
   assign sqy      = SW'(dy) * SW'(dy);
   assign dist_new = DW'(sqx) + DW'(sqy);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (cnt_q == AW'(NPoints - 1)) state_d = DRAIN;
         DRAIN:   state_d = VOTE;
         VOTE:    state_d = DONE;
         DONE:    if (out_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Status outputs are registered from the next state
   always_comb begin
      in_ready_d  = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
      mem_re_d    = (state_d == RUN);
      out_valid_d = (state_d == DONE);
   end

   always_comb begin
      cnt_d = cnt_q;
      if (accept)
         cnt_d = '0;
      else if ((state_q == RUN) && (cnt_q != AW'(NPoints - 1)))
         cnt_d = cnt_q + AW'(1);
   end

   // Strict-less insertion keeps the earlier point ahead on equal distance
   always_comb begin
      dist_d = dist_q;
      cls_d  = cls_q;
      if (accept) begin
         for (int unsigned k = 0; k < K; k++) begin
            dist_d[k] = '1;
            cls_d[k]  = '0;
         end
      end else if (rvalid_q) begin
         for (int j = int'(K) - 1; j > 0; j--) begin
            if (dist_new < dist_q[j]) begin
               if (dist_new < dist_q[j-1]) begin
                  dist_d[j] = dist_q[j-1];
                  cls_d[j]  = cls_q[j-1];
               end else begin
                  dist_d[j] = dist_new;
                  cls_d[j]  = mem_class_i;
               end
            end
         end
         if (dist_new < dist_q[0]) begin
            dist_d[0] = dist_new;
            cls_d[0]  = mem_class_i;
         end
      end
   end

   // Majority vote; lowest class index wins a tie
   always_comb begin
      vote_cls = '0;
      best_cnt = '0;
      cls_cnt  = '0;
      for (int unsigned c = 0; c < Classes; c++) begin
         cls_cnt = '0;
         for (int unsigned k = 0; k < K; k++)
            if (cls_q[k] == CW'(c)) cls_cnt = cls_cnt + NW'(1);
         if (cls_cnt > best_cnt) begin
            best_cnt = cls_cnt;
            vote_cls = CW'(c);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q       <= '0;
         qx_q        <= '0;
         qy_q        <= '0;
         rvalid_q    <= 1'b0;
         for (int unsigned k = 0; k < K; k++) begin
            dist_q[k] <= '1;
            cls_q[k]  <= '0;
         end
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         mem_re_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_class_q <= '0;
         out_min_q   <= '0;
      end else begin
         if (accept) begin
            qx_q <= in_x_i;
            qy_q <= in_y_i;
         end
         cnt_q       <= cnt_d;
         rvalid_q    <= mem_re_q;
         dist_q      <= dist_d;
         cls_q       <= cls_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         mem_re_q    <= mem_re_d;
         out_valid_q <= out_valid_d;
         if (state_q == VOTE) begin
            out_class_q <= vote_cls;
            out_min_q   <= dist_q[0];
         end
      end
   end

   assign in_ready_o     = in_ready_q;
   assign busy_o         = busy_q;
   assign mem_re_o       = mem_re_q;
   assign mem_addr_o     = cnt_q;
   assign out_valid_o    = out_valid_q;
   assign out_class_o    = out_class_q;
   assign out_min_dist_o = out_min_q;

endmodule

// File: tb/tb_knn_seq_ctrl.sv
// Directed bench for knn_seq_ctrl: three configurations (default, K=1, Classes=4) share one
// point-memory image with per-instance synchronous read ports.
module tb_knn_seq_ctrl;

   localparam int unsigned NP = 17;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] in_x, in_y;
   logic        out_ready;
   int          sel;
   int          checks = 0;
   int          errors = 0;

   logic [15:0] mx [NP];
   logic [15:0] my [NP];
   logic [1:0]  mc [NP];

   always #5 clk = ~clk;

   // Instance 0: defaults (K=3, Classes=2)
   logic iv0, ir0, re0, ov0, busy0, rc0, oc0;
   logic [4:0]  addr0;
   logic [15:0] rx0, ry0;
   logic [32:0] om0;
   assign iv0 = in_valid & (sel == 0);
   knn_seq_ctrl u_dut (
      .clk_i(clk), .rst_i(rst), .in_valid_i(iv0), .in_ready_o(ir0), .in_x_i(in_x), .in_y_i(in_y),
      .mem_re_o(re0), .mem_addr_o(addr0), .mem_x_i(rx0), .mem_y_i(ry0), .mem_class_i(rc0),
      .out_valid_o(ov0), .out_ready_i(out_ready), .out_class_o(oc0), .out_min_dist_o(om0), .busy_o(busy0));
   always_ff @(posedge clk) if (re0) begin rx0 <= mx[addr0]; ry0 <= my[addr0]; rc0 <= mc[addr0][0]; end

   // Instance 1: K=1
   logic iv1, ir1, re1, ov1, busy1, rc1, oc1;
   logic [4:0]  addr1;
   logic [15:0] rx1, ry1;
   logic [32:0] om1;
   assign iv1 = in_valid & (sel == 1);
   knn_seq_ctrl #(.NPoints(17), .K(1), .Classes(2), .CoordW(16)) u_dut_k1 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(iv1), .in_ready_o(ir1), .in_x_i(in_x), .in_y_i(in_y),
      .mem_re_o(re1), .mem_addr_o(addr1), .mem_x_i(rx1), .mem_y_i(ry1), .mem_class_i(rc1),
      .out_valid_o(ov1), .out_ready_i(out_ready), .out_class_o(oc1), .out_min_dist_o(om1), .busy_o(busy1));
   always_ff @(posedge clk) if (re1) begin rx1 <= mx[addr1]; ry1 <= my[addr1]; rc1 <= mc[addr1][0]; end

   // Instance 2: Classes=4, K=3
   logic iv2, ir2, re2, ov2, busy2;
   logic [1:0]  rc2, oc2;
   logic [4:0]  addr2;
   logic [15:0] rx2, ry2;
   logic [32:0] om2;
   assign iv2 = in_valid & (sel == 2);
   knn_seq_ctrl #(.NPoints(17), .K(3), .Classes(4), .CoordW(16)) u_dut_c4 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(iv2), .in_ready_o(ir2), .in_x_i(in_x), .in_y_i(in_y),
      .mem_re_o(re2), .mem_addr_o(addr2), .mem_x_i(rx2), .mem_y_i(ry2), .mem_class_i(rc2),
      .out_valid_o(ov2), .out_ready_i(out_ready), .out_class_o(oc2), .out_min_dist_o(om2), .busy_o(busy2));
   always_ff @(posedge clk) if (re2) begin rx2 <= mx[addr2]; ry2 <= my[addr2]; rc2 <= mc[addr2]; end

   logic        s_ir, s_re, s_ov, s_busy;
   logic [1:0]  s_cls;
   logic [32:0] s_min;
   logic [4:0]  s_addr;
   always_comb begin
      case (sel)
         1: begin s_ir = ir1; s_re = re1; s_ov = ov1; s_busy = busy1; s_cls = {1'b0, oc1}; s_min = om1; s_addr = addr1; end
         2: begin s_ir = ir2; s_re = re2; s_ov = ov2; s_busy = busy2; s_cls = oc2; s_min = om2; s_addr = addr2; end
         default: begin s_ir = ir0; s_re = re0; s_ov = ov0; s_busy = busy0; s_cls = {1'b0, oc0}; s_min = om0; s_addr = addr0; end
      endcase
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one query, measure latency and read count, check the result at first out_valid
   task automatic run_query(input int inst, input logic [15:0] qx, input logic [15:0] qy,
                            input logic [1:0] exp_cls, input logic [32:0] exp_min, input string tag);
      int lat, re_cnt;
      @(negedge clk);
      sel = inst; in_x = qx; in_y = qy; in_valid = 1'b1;
      check({tag, "_in_ready"}, 64'(s_ir), 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0; re_cnt = 0;
      do begin
         @(negedge clk);
         lat++;
         if (s_re) re_cnt++;
      end while (!s_ov && lat < 100);
      check({tag, "_latency"}, 64'(lat), 64'd20);
      check({tag, "_reads"}, 64'(re_cnt), 64'd17);
      check({tag, "_class"}, 64'(s_cls), 64'(exp_cls));
      check({tag, "_min"}, 64'(s_min), 64'(exp_min));
   endtask

   task automatic expect_idle(input string tag);
      @(negedge clk);
      check({tag, "_ready_again"}, 64'(s_ir), 64'd1);
      check({tag, "_valid_low"}, 64'(s_ov), 64'd0);
   endtask

   task automatic load_line();
      for (int i = 0; i < int'(NP); i++) begin
         mx[i] = 16'(i); my[i] = 16'd0; mc[i] = (i == 2 || i == 5) ? 2'd1 : 2'd0;
      end
   endtask

   task automatic load_pair();
      for (int i = 0; i < int'(NP); i++) begin
         mx[i] = 16'(100 + i); my[i] = 16'd100; mc[i] = 2'd1;
      end
      mx[3] = 16'd11; my[3] = 16'd11; mc[3] = 2'd1;
      mx[7] = 16'd9;  my[7] = 16'd9;  mc[7] = 2'd0;
   endtask

   task automatic load_max();
      for (int i = 0; i < int'(NP); i++) begin
         mx[i] = 16'hFFFF; my[i] = 16'hFFFF; mc[i] = 2'd0;
      end
   endtask

   task automatic load_c4();
      for (int i = 0; i < int'(NP); i++) begin
         mx[i] = 16'(200 + i); my[i] = 16'd200; mc[i] = 2'd0;
      end
      mx[4]  = 16'd51; my[4]  = 16'd50; mc[4]  = 2'd3;
      mx[9]  = 16'd50; my[9]  = 16'd52; mc[9]  = 2'd1;
      mx[12] = 16'd53; my[12] = 16'd50; mc[12] = 2'd2;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1; sel = 0;
      load_line();
      repeat (2) @(negedge clk);
      check("rst_in_ready", 64'(s_ir), 64'd1);
      check("rst_busy", 64'(s_busy), 64'd0);
      check("rst_mem_re", 64'(s_re), 64'd0);
      check("rst_addr", 64'(s_addr), 64'd0);
      check("rst_out_valid", 64'(s_ov), 64'd0);
      check("rst_class", 64'(s_cls), 64'd0);
      check("rst_min", 64'(s_min), 64'd0);
      rst = 1'b0;

      run_query(0, 16'd0, 16'd0, 2'd0, 33'd0, "line_q00");
      expect_idle("line_q00");
      run_query(0, 16'd20, 16'd0, 2'd0, 33'd16, "line_q20");
      expect_idle("line_q20");

      load_pair();
      run_query(1, 16'd10, 16'd10, 2'd1, 33'd2, "tie_k1");
      expect_idle("tie_k1");
      run_query(0, 16'd10, 16'd10, 2'd1, 33'd2, "pair_k3");
      expect_idle("pair_k3");

      load_max();
      run_query(1, 16'd0, 16'd0, 2'd0, 33'h1_FFFC_0002, "max_dist");
      expect_idle("max_dist");

      load_c4();
      run_query(2, 16'd50, 16'd50, 2'd1, 33'd1, "c4_tie3");
      expect_idle("c4_tie3");
      mc[12] = 2'd3;
      run_query(2, 16'd50, 16'd50, 2'd3, 33'd1, "c4_major");
      expect_idle("c4_major");

      // Backpressure: result held, new queries refused
      load_line();
      out_ready = 1'b0;
      run_query(0, 16'd20, 16'd0, 2'd0, 33'd16, "hold");
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("hold_valid", 64'(s_ov), 64'd1);
         check("hold_class", 64'(s_cls), 64'd0);
         check("hold_min", 64'(s_min), 64'd16);
         check("hold_in_ready", 64'(s_ir), 64'd0);
         in_valid = ~in_valid;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      expect_idle("hold");

      // Reset in cycle 8 of a run
      @(negedge clk);
      sel = 0; in_x = 16'd0; in_y = 16'd0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (7) @(negedge clk);
      check("run_mem_re_c7", 64'(s_re), 64'd1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_in_ready", 64'(s_ir), 64'd1);
      check("mid_rst_busy", 64'(s_busy), 64'd0);
      check("mid_rst_mem_re", 64'(s_re), 64'd0);
      check("mid_rst_addr", 64'(s_addr), 64'd0);
      check("mid_rst_out_valid", 64'(s_ov), 64'd0);
      check("mid_rst_class", 64'(s_cls), 64'd0);
      check("mid_rst_min", 64'(s_min), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("post_rst_mem_re", 64'(s_re), 64'd0);
         check("post_rst_in_ready", 64'(s_ir), 64'd1);
      end
      run_query(0, 16'd20, 16'd0, 2'd0, 33'd16, "post_rst");
      expect_idle("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
